// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding, the scoreboard entry and the helpers that read or build entries.
package pipe_hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        CS_RUN   = 2'd0,
        CS_RAW   = 2'd1,
        CS_MEMW  = 2'd2,
        CS_FLUSH = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic                 wren;
    } sb_entry_t;

    // Writes to x0 never produce a value a later instruction could depend on.
    function automatic sb_entry_t sb_entry(input logic [REG_IDX_W-1:0] rd, input logic wren);
        sb_entry_t e;
        e.rd   = rd;
        e.wren = wren && (rd != {REG_IDX_W{1'b0}});
        return e;
    endfunction

    function automatic logic sb_hit(input sb_entry_t e, input logic [REG_IDX_W-1:0] idx);
        return e.wren && (e.rd == idx);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle: ID/EX/MEM status into the hazard controller, stall/flush/bubble controls out.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic                 id_valid;
    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_rs1_used;
    logic                 id_rs2_used;
    logic [REG_IDX_W-1:0] id_rd;
    logic                 id_rd_wren;
    logic                 ex_redirect;
    logic                 mem_req;
    logic                 mem_ack;

    logic                 if_stall;
    logic                 id_stall;
    logic                 idex_bubble;
    logic                 ifid_flush;
    logic                 idex_flush;
    logic                 exmem_hold;
    logic                 memwb_bubble;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_wren,
        output ex_redirect, mem_req, mem_ack,
        input  if_stall, id_stall, idex_bubble, ifid_flush, idex_flush, exmem_hold, memwb_bubble
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_wren,
        input  ex_redirect, mem_req, mem_ack,
        output if_stall, id_stall, idex_bubble, ifid_flush, idex_flush, exmem_hold, memwb_bubble
    );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Destination tracker for the EX, MEM and WB stages, kept in lock-step with the datapath registers.
// Reports whether either ID source register is still to be written by an instruction in flight.
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_i,
    input  logic                 freeze_i,
    input  logic                 clear_wb_i,
    input  logic [REG_IDX_W-1:0] ld_rd_i,
    input  logic                 ld_wren_i,
    input  logic [REG_IDX_W-1:0] rs1_i,
    input  logic [REG_IDX_W-1:0] rs2_i,
    output logic                 rs1_hit_o,
    output logic                 rs2_hit_o
);

    sb_entry_t ex_q, mem_q, wb_q;
    sb_entry_t ex_d, mem_d, wb_d;

    // Next-state selection: freeze holds EX/MEM, shift advances, clear empties WB.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (freeze_i) begin
            ex_d  = ex_q;
            mem_d = mem_q;
        end else if (shift_i) begin
            ex_d  = sb_entry(ld_rd_i, ld_wren_i);
            mem_d = ex_q;
        end else begin
            ex_d  = ex_q;
            mem_d = mem_q;
        end
        if (clear_wb_i) begin
            wb_d = sb_entry({REG_IDX_W{1'b0}}, 1'b0);
        end else if (shift_i && !freeze_i) begin
            wb_d = mem_q;
        end else begin
            wb_d = wb_q;
        end
    end

    // Entry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= sb_entry({REG_IDX_W{1'b0}}, 1'b0);
            mem_q <= sb_entry({REG_IDX_W{1'b0}}, 1'b0);
            wb_q  <= sb_entry({REG_IDX_W{1'b0}}, 1'b0);
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign rs1_hit_o = sb_hit(ex_q, rs1_i) || sb_hit(mem_q, rs1_i) || sb_hit(wb_q, rs1_i);
    assign rs2_hit_o = sb_hit(ex_q, rs2_i) || sb_hit(mem_q, rs2_i) || sb_hit(wb_q, rs2_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline hazard controller: RAW interlock without forwarding, memory-wait freeze
// and branch-redirect flush, with a registered debug state and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz_if,
    output logic [1:0]        ctrl_state_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [1:0] ST_RUN   = CS_RUN;
    localparam logic [1:0] ST_RAW   = CS_RAW;
    localparam logic [1:0] ST_MEMW  = CS_MEMW;
    localparam logic [1:0] ST_FLUSH = CS_FLUSH;

    logic             rs1_hit, rs2_hit;
    logic             raw_hazard, mem_wait;
    logic [1:0]       state_d, ctrl_state_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic             if_stall_c, id_stall_c, idex_bubble_c, ifid_flush_c;
    logic             idex_flush_c, exmem_hold_c, memwb_bubble_c;

    assign mem_wait   = hz_if.mem_req && !hz_if.mem_ack;
    assign raw_hazard = hz_if.id_valid &&
                        ((hz_if.id_rs1_used && rs1_hit) || (hz_if.id_rs2_used && rs2_hit));

    // Only a RUN cycle lets the ID instruction into EX; a stalled or squashed one leaves a bubble.
    hazard_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .shift_i    (!mem_wait),
        .freeze_i   (mem_wait),
        .clear_wb_i (mem_wait),
        .ld_rd_i    (hz_if.id_rd),
        .ld_wren_i  ((state_d == ST_RUN) && hz_if.id_valid && hz_if.id_rd_wren),
        .rs1_i      (hz_if.id_rs1),
        .rs2_i      (hz_if.id_rs2),
        .rs1_hit_o  (rs1_hit),
        .rs2_hit_o  (rs2_hit)
    );

    // Current-cycle decision. A redirect under a memory wait simply persists until the ack.
    always_comb begin
        state_d = ST_RUN;
        if (rst) begin
            state_d = ST_RUN;
        end else if (mem_wait) begin
            state_d = ST_MEMW;
        end else if (hz_if.ex_redirect) begin
            state_d = ST_FLUSH;
        end else if (raw_hazard) begin
            state_d = ST_RAW;
        end else begin
            state_d = ST_RUN;
        end
    end

    // Control decode of the current-cycle decision.
    always_comb begin
        if_stall_c     = 1'b0;
        id_stall_c     = 1'b0;
        idex_bubble_c  = 1'b0;
        ifid_flush_c   = 1'b0;
        idex_flush_c   = 1'b0;
        exmem_hold_c   = 1'b0;
        memwb_bubble_c = 1'b0;
        case (state_d)
            ST_RAW: begin
                if_stall_c    = 1'b1;
                id_stall_c    = 1'b1;
                idex_bubble_c = 1'b1;
            end
            ST_MEMW: begin
                if_stall_c     = 1'b1;
                id_stall_c     = 1'b1;
                exmem_hold_c   = 1'b1;
                memwb_bubble_c = 1'b1;
            end
            ST_FLUSH: begin
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
            end
            default: begin
                if_stall_c = 1'b0;
            end
        endcase
    end

    assign hz_if.if_stall     = if_stall_c;
    assign hz_if.id_stall     = id_stall_c;
    assign hz_if.idex_bubble  = idex_bubble_c;
    assign hz_if.ifid_flush   = ifid_flush_c;
    assign hz_if.idex_flush   = idex_flush_c;
    assign hz_if.exmem_hold   = exmem_hold_c;
    assign hz_if.memwb_bubble = memwb_bubble_c;

    // Saturating stall counter next value.
    always_comb begin
        if (if_stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Debug state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_state_q <= ST_RUN;
            stall_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            ctrl_state_q <= state_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Masked so the debug view already reads as reset during the cycle rst is first seen.
    assign ctrl_state_o = rst ? ST_RUN : ctrl_state_q;
    assign stall_cnt_o  = rst ? {CNT_W{1'b0}} : stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Cycle-vector bench for pipe_hazard_ctrl: per-cycle stimulus with hand-derived expected controls,
// queued on drive and checked on the following falling edge, plus a bounded RAW stall sequence.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cnt;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .hz_if        (hz),
        .ctrl_state_o (ctrl_state),
        .stall_cnt_o  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        wr;
        logic        redir;
        logic        mreq;
        logic        mack;
        logic [6:0]  exp_ctl;
        logic [1:0]  exp_st;
        logic [15:0] exp_cnt;
        string       name;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t v(input logic r, input logic vld, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic wr, input logic redir, input logic mreq, input logic mack,
                               input logic [6:0] ctl, input logic [1:0] st, input logic [15:0] cnt,
                               input string name);
        vec_t x;
        x.rst = r; x.vld = vld; x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2;
        x.rd = rd; x.wr = wr; x.redir = redir; x.mreq = mreq; x.mack = mack;
        x.exp_ctl = ctl; x.exp_st = st; x.exp_cnt = cnt; x.name = name;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_inputs(input vec_t x);
        rst            = x.rst;
        hz.id_valid    = x.vld;
        hz.id_rs1      = x.rs1;
        hz.id_rs1_used = x.u1;
        hz.id_rs2      = x.rs2;
        hz.id_rs2_used = x.u2;
        hz.id_rd       = x.rd;
        hz.id_rd_wren  = x.wr;
        hz.ex_redirect = x.redir;
        hz.mem_req     = x.mreq;
        hz.mem_ack     = x.mack;
    endtask

    // Control bit order: {if_stall, id_stall, idex_bubble, ifid_flush, idex_flush, exmem_hold, memwb_bubble}
    task automatic check_out();
        vec_t e;
        logic [6:0] ctl;
        if (exp_q.size() == 0) begin
            chk("queue_underflow", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            ctl = {hz.if_stall, hz.id_stall, hz.idex_bubble, hz.ifid_flush,
                   hz.idex_flush, hz.exmem_hold, hz.memwb_bubble};
            chk({e.name, "_ctl"}, {25'd0, ctl}, {25'd0, e.exp_ctl});
            chk({e.name, "_state"}, {30'd0, ctrl_state}, {30'd0, e.exp_st});
            chk({e.name, "_cnt"}, {16'd0, stall_cnt}, {16'd0, e.exp_cnt});
        end
    endtask

    task automatic drive(input vec_t x);
        @(posedge clk);
        #1;
        set_inputs(x);
        exp_q.push_back(x);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        vec_t rs;
        int   n_stall;
        logic done;

        rs = v(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 2'd0, 16'd0, "reset");
        set_inputs(rs);

        // RAW on x5 for three cycles, then x0 never hazards, invalid ID never hazards
        tbl.push_back(rs);
        tbl.push_back(rs);
        tbl.push_back(v(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 2'd0, 16'd0, "A_addi"));
        tbl.push_back(v(1'b0, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 7'h70, 2'd0, 16'd0, "A_raw1"));
        tbl.push_back(v(1'b0, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 7'h70, 2'd1, 16'd1, "A_raw2"));
        tbl.push_back(v(1'b0, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 7'h70, 2'd1, 16'd2, "A_raw3"));
        tbl.push_back(v(1'b0, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 2'd1, 16'd3, "A_run"));
        tbl.push_back(v(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 2'd0, 16'd3, "A_x0_wr"));
        tbl.push_back(v(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 2'd0, 16'd3, "A_x0_rd"));
        tbl.push_back(v(1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 2'd0, 16'd3, "A_novalid"));
        // Four-cycle memory wait, then ack advances
        tbl.push_back(rs);
        tbl.push_back(v(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h63, 2'd0, 16'd0, "B_memw1"));
        tbl.push_back(v(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h63, 2'd2, 16'd1, "B_memw2"));
        tbl.push_back(v(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h63, 2'd2, 16'd2, "B_memw3"));
        tbl.push_back(v(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h63, 2'd2, 16'd3, "B_memw4"));
        tbl.push_back(v(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 7'h00, 2'd2, 16'd4, "B_ack"));
        tbl.push_back(v(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 2'd0, 16'd4, "B_idle"));
        // Redirect deferred by a 2-cycle wait; frozen x9 must still hazard after the flush
        tbl.push_back(rs);
        tbl.push_back(v(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 2'd0, 16'd0, "C_prod"));
        tbl.push_back(v(1'b0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 7'h63, 2'd0, 16'd0, "C_memw1"));
        tbl.push_back(v(1'b0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 7'h63, 2'd2, 16'd1, "C_memw2"));
        tbl.push_back(v(1'b0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1, 7'h0C, 2'd2, 16'd2, "C_flush"));
        tbl.push_back(v(1'b0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 7'h70, 2'd3, 16'd2, "C_raw_mem"));
        tbl.push_back(v(1'b0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 7'h70, 2'd1, 16'd3, "C_raw_wb"));
        tbl.push_back(v(1'b0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 2'd1, 16'd4, "C_run"));
        // Redirect coinciding with RAW: flush wins, squashed x12 never enters EX
        tbl.push_back(rs);
        tbl.push_back(v(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 2'd0, 16'd0, "D_prod"));
        tbl.push_back(v(1'b0, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 7'h0C, 2'd0, 16'd0, "D_flush_raw"));
        tbl.push_back(v(1'b0, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 2'd3, 16'd0, "D_ex_inv"));
        tbl.push_back(v(1'b0, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h70, 2'd0, 16'd0, "D_raw_wb"));
        tbl.push_back(v(1'b0, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 2'd1, 16'd1, "D_run"));
        // Reset during a RAW stall and during a memory wait
        tbl.push_back(rs);
        tbl.push_back(v(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 2'd0, 16'd0, "E_prod"));
        tbl.push_back(v(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 7'h70, 2'd0, 16'd0, "E_raw1"));
        tbl.push_back(v(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 7'h70, 2'd1, 16'd1, "E_raw2"));
        tbl.push_back(v(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 2'd0, 16'd0, "E_rst"));
        tbl.push_back(v(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 2'd0, 16'd0, "E_after"));
        tbl.push_back(v(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h63, 2'd0, 16'd0, "E_memw"));
        tbl.push_back(v(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 2'd0, 16'd0, "E_rst_memw"));
        tbl.push_back(v(1'b0, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 2'd0, 16'd0, "E_clr"));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
        end

        // Bounded RAW stall through rs2 on x31: expect exactly three stall cycles
        drive(rs);
        drive(v(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 2'd0, 16'd0, "H_prod"));
        @(posedge clk);
        #1;
        set_inputs(v(1'b0, 1'b1, 5'd2, 1'b1, 5'd31, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 2'd0, 16'd0, "H_cons"));
        n_stall = 0;
        done    = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (hz.if_stall) begin
                n_stall++;
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
            end
        end
        chk("H_stall_ended", {31'd0, done}, 32'd1);
        chk("H_stall_len", n_stall, 32'd3);
        chk("H_cnt", {16'd0, stall_cnt}, 32'd3);
        chk("H_state", {30'd0, ctrl_state}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 id_valid  in  1  a real instruction occupies ID.
REQ-004 id_rs1, id_rs2  in  5 each  ID source register indices.
REQ-005 id_rs1_used, id_rs2_used  in  1 each  source actually read by the instruction.
REQ-006 id_rd  in  5; id_rd_wren  in  1  ID destination index and write enable.
REQ-007 ex_redirect  in  1  taken branch/jump resolved in EX.
REQ-008 mem_req  in  1; mem_ack  in  1  MEM-stage data access pending and completed.
REQ-009 if_stall, id_stall  out  1 each  hold PC and IF/ID register.
REQ-010 idex_bubble  out  1  load NOP (all wren/mem_wren zero) into ID/EX.
REQ-011 ifid_flush, idex_flush  out  1 each  squash the wrong-path instruction.
REQ-012 exmem_hold  out  1  hold EX/MEM (and ID/EX) contents.
REQ-013 memwb_bubble  out  1  load NOP into MEM/WB.
REQ-014 ctrl_state  out  2  current FSM state (debug).
REQ-015 stall_cnt  out  16  saturating count of if_stall cycles.

Function
REQ-016 The block SHALL keep a 3-entry scoreboard {rd, wren} for the EX, MEM and WB stages, mirroring the datapath pipeline registers.
REQ-017 Entries with rd = 0 SHALL be treated as wren = 0.
REQ-018 RAW hazard SHALL be: id_valid, and (rs1_used and rs1 matches a valid entry) or (rs2_used and rs2 matches a valid entry); no forwarding is assumed.
REQ-019 FSM states: RUN=0, RAW=1, MEMW=2, FLUSH=3; priority MEMW > FLUSH > RAW > RUN, evaluated combinationally each cycle.
REQ-020 MEMW (mem_req and not mem_ack): assert if_stall, id_stall, exmem_hold, memwb_bubble; scoreboard EX/MEM entries frozen; WB entry cleared at the edge.
REQ-021 FLUSH (ex_redirect, not MEMW): assert ifid_flush, idex_flush, no stall; at the edge scoreboard shifts (EX->MEM->WB) and EX loads invalid.
REQ-022 RAW (hazard, not MEMW or FLUSH): assert if_stall, id_stall, idex_bubble; scoreboard shifts with invalid into EX; a stall lasts at most 3 cycles.
REQ-023 RUN: all control outputs 0; scoreboard shifts, EX loads {id_rd, id_rd_wren and id_valid}.
REQ-024 Redirect during MEMW SHALL be deferred; ex_redirect stays asserted because EX is held, and the flush occurs in the cycle mem_ack arrives.
REQ-025 A redirect coinciding with a RAW hazard SHALL take FLUSH; the hazarding ID instruction is squashed.
REQ-026 The mem_ack cycle SHALL be RUN behaviour (pipeline advances) unless FLUSH or RAW applies.
REQ-027 ctrl_state SHALL be registered: it reflects the state decided in the previous cycle.
REQ-028 stall_cnt SHALL increment in every cycle with if_stall = 1 and hold at 16'hFFFF.

Reset
REQ-029 While rst = 1: scoreboard entries invalid, ctrl_state = RUN, stall_cnt = 0, and all control outputs forced to 0.
REQ-030 Reset asserted mid-stall or mid-MEMW SHALL abort it; the first cycle after reset is RUN.

Structure
REQ-031 A shared package SHALL hold the state enum (2-bit), the register-index width (5) and the counter width (16).
REQ-032 The scoreboard SHALL be a sub-module, hazard_scoreboard (shift/freeze/clear controls, match outputs).

Verification
REQ-033 Program: addi x5 in ID, then add x6,x5,x1 next -> RAW for 3 cycles, idex_bubble = 1 each cycle, stall_cnt = 3.
REQ-034 Hazard on x0 (rd = 0, rs1 = 0) -> no stall, ctrl_state stays RUN.
REQ-035 mem_req = 1, mem_ack low for 4 cycles -> exmem_hold and memwb_bubble high for exactly 4 cycles, stall_cnt = 4.
REQ-036 ex_redirect during a 2-cycle MEMW -> flush asserted only in the mem_ack cycle, ifid_flush = idex_flush = 1 for 1 cycle.
REQ-037 Redirect and RAW in the same cycle -> FLUSH, no if_stall, EX scoreboard entry invalid afterwards.
REQ-038 rst pulsed during a RAW stall -> outputs 0 in the same cycle, stall_cnt = 0, RUN the next cycle.
